jk_modn_updown_counter: RTL

Parametrised modulo-N up/down counter, the general successor to the fixed mod-7 JK counter. The modulus is selectable at run time. The block adds synchronous load, count enable, a terminal-count output for cascading, and a sticky load-error flag. It is used as a building block for divider chains, timers and sequence generators in the counter library.

---
 rtl/jk_modn_updown_counter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/jk_modn_updown_counter.sv
// jk_modn_updown_counter
// Run-time selectable modulo-N up/down counter with synchronous load,
// count enable, combinational terminal count and a sticky load-error flag.
//
// Build option: define JK_MODN_STRUCT_EN to build the q register from
// per-bit JK flip-flop cells (jk_modn_jk_cell / jk_modn_jk_cell_pre).
// Without it, q is a plain behavioural register. Cycle behaviour of q, tc
// and err is identical in both builds.
//
// Count range is 0..LAST, where LAST = mod_n-1, or all-ones when mod_n = 0.
// Per-edge priority: reset > load > en > hold.
module jk_modn_updown_counter #(
    parameter int          WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_n,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             err
);

    localparam logic [WIDTH-1:0] RESET_Q = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] last;
    logic             at_top;
    logic             at_bottom;
    logic             wrap;
    logic             load_ok;
    logic [WIDTH-1:0] q_next;

    // Highest valid count value; mod_n = 0 selects the full 2^WIDTH range,
    // which the WIDTH-bit subtraction already yields as all-ones.
    always_comb begin
        last = mod_n - ONE;
    end

    // Wrap detection. The "q > last" terms catch a modulus that was reduced
    // below the current count; the next enabled step wraps back into range.
    always_comb begin
        at_top    = (q >= last);
        at_bottom = (q == '0) || (q > last);
        wrap      = up_dn ? at_top : at_bottom;
        load_ok   = (load_val <= last);
    end

    // Terminal count: high exactly in the cycle whose edge wraps q, so it can
    // drive the enable of the next cascaded stage.
    always_comb begin
        tc = en & ~load & wrap;
    end

    // Next-state selection with load taking priority over counting.
    always_comb begin
        q_next = q;
        if (load) begin
            q_next = load_ok ? load_val : '0;
        end else if (en) begin
            if (up_dn) begin
                q_next = at_top ? '0 : (q + ONE);
            end else begin
                q_next = at_bottom ? last : (q - ONE);
            end
        end
    end

    // Sticky error: set by an out-of-range load, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (load && !load_ok) begin
            err <= 1'b1;
        end
    end

`ifdef JK_MODN_STRUCT_EN

    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] jk_j;
    logic [WIDTH-1:0] jk_k;
    logic             use_sr;

    // Plain counting steps drive J = K = toggle. Loads and wraps jump to an
    // arbitrary target, so those use the set/reset form of J/K instead.
    // Both forms land on q_next; the split mirrors how the cells are used.
    always_comb begin
        toggle = q_next ^ q;
        use_sr = load | (en & wrap);
        if (use_sr) begin
            jk_j = q_next & ~q;
            jk_k = ~q_next & q;
        end else begin
            jk_j = toggle;
            jk_k = toggle;
        end
    end

    // One JK cell per bit; bits whose reset value is 1 use the preset cell.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (RESET_Q[i]) begin : g_pre
            jk_modn_jk_cell_pre u_cell (
                .clk   (clk),
                .reset (reset),
                .j     (jk_j[i]),
                .k     (jk_k[i]),
                .q     (q[i])
            );
        end else begin : g_clr
            jk_modn_jk_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .j     (jk_j[i]),
                .k     (jk_k[i]),
                .q     (q[i])
            );
        end
    end

`else

    // Behavioural count register with asynchronous reset to RESET_VAL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_Q;
        end else begin
            q <= q_next;
        end
    end

`endif

endmodule

`ifdef JK_MODN_STRUCT_EN

// JK flip-flop cell, asynchronous clear to 0.
module jk_modn_jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    // Standard JK truth table: hold, reset, set, toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// JK flip-flop cell, asynchronous preset to 1.
module jk_modn_jk_cell_pre (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    // Same JK truth table, reset drives the cell to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b1;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

`endif
